// File: rtl/digit_pulse_reader.sv
// Qualifies an asynchronous optical-sensor line into single-cycle digit (D)
// and read-complete (C) pulses for the downstream sticker-length counter.
module digit_pulse_reader #(
  parameter int unsigned MIN_PULSE   = 2,
  parameter int unsigned MAX_PULSE   = 8,
  parameter int unsigned GAP_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic s_in,
  output logic D,
  output logic C,
  output logic err,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic             s_meta;
  logic             s_sync;
  logic             s_dly;
  logic [1:0]       fill;
  logic             armed;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] gap;
  logic             digits_seen;

  logic rise;
  logic width_ok;
  logic gap_last;

  assign rise     = s_sync & ~s_dly;
  assign width_ok = (width >= CNT_W'(MIN_PULSE)) && (width <= CNT_W'(MAX_PULSE));
  assign gap_last = (gap == CNT_W'(GAP_TIMEOUT - 1));

  // Mealy decode: pulses fire in the same cycle as the qualifying line event.
  assign D    = (state == HIGH) && !s_sync && width_ok;
  assign err  = (state == HIGH) && !s_sync && !width_ok;
  assign C    = (state == GAP) && !s_sync && digits_seen && gap_last;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      s_meta      <= 1'b0;
      s_sync      <= 1'b0;
      s_dly       <= 1'b0;
      fill        <= 2'b00;
      armed       <= 1'b0;
      width       <= '0;
      gap         <= '0;
      digits_seen <= 1'b0;
    end else begin
      s_meta <= s_in;
      s_sync <= s_meta;
      s_dly  <= s_sync;
      fill   <= {fill[0], 1'b1};
      // A mark already in progress when reset released is not a real rise;
      // only accept rises once the synchronized line has been seen low.
      if (fill[1] && !s_sync) begin
        armed <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise && enable && armed) begin
            state <= HIGH;
            width <= CNT_W'(1);
          end
        end

        HIGH: begin
          if (s_sync) begin
            if (width != CNT_W'(MAX_PULSE + 1)) begin
              width <= width + CNT_W'(1);
            end
          end else begin
            width <= '0;
            if (width_ok) begin
              digits_seen <= 1'b1;
              state       <= GAP;
              gap         <= CNT_W'(1);
            end else if (digits_seen) begin
              state <= GAP;
              gap   <= CNT_W'(1);
            end else begin
              state <= IDLE;
            end
          end
        end

        GAP: begin
          if (s_sync) begin
            state <= HIGH;
            width <= CNT_W'(1);
            gap   <= '0;
          end else if (gap_last) begin
            state       <= IDLE;
            gap         <= '0;
            digits_seen <= 1'b0;
          end else begin
            gap <= gap + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_pulse_reader.sv
// Directed bench for digit_pulse_reader: drives mark/space patterns on s_in
// and checks pulse counts and cycle positions against hand-computed values.
module tb_digit_pulse_reader;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic s_in;
  logic d;
  logic c;
  logic err;
  logic busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int s0;

  int   d_q[$];
  int   c_q[$];
  int   e_q[$];
  int   n_busy;
  int   n_overlap;
  int   busy_after_err;
  logic err_prev;

  always #5 clk = ~clk;

  digit_pulse_reader dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .s_in  (s_in),
    .D     (d),
    .C     (c),
    .err   (err),
    .busy  (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1000;
  endfunction

  task automatic clear();
    d_q.delete();
    c_q.delete();
    e_q.delete();
    n_busy         = 0;
    n_overlap      = 0;
    busy_after_err = -1;
    err_prev       = 1'b0;
    s0             = cyc;
  endtask

  // One clock: drive s_in just after the edge, sample outputs on the falling edge.
  task automatic tick(input logic v);
    @(posedge clk);
    #1 s_in = v;
    @(negedge clk);
    cyc++;
    if (d)   d_q.push_back(cyc);
    if (c)   c_q.push_back(cyc);
    if (err) e_q.push_back(cyc);
    if (busy) n_busy++;
    if (d && c) n_overlap++;
    if (err_prev) busy_after_err = int'(busy);
    err_prev = err;
  endtask

  task automatic run(input logic v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_d"},    int'(d),    0);
    chk({tag, "_c"},    int'(c),    0);
    chk({tag, "_err"},  int'(err),  0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    s_in   = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("in_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("after_release");
    run(1'b0, 5);

    // Single 4-cycle digit
    clear();
    run(1'b1, 4);
    run(1'b0, 20);
    chk("s1_d_count", d_q.size(), 1);
    chk("s1_d_cycle", at(d_q, 0) - s0, 7);
    chk("s1_c_count", c_q.size(), 1);
    chk("s1_c_after_d", at(c_q, 0) - at(d_q, 0), 15);
    chk("s1_err_count", e_q.size(), 0);
    chk("s1_busy_cycles", n_busy, 19);
    chk("s1_overlap", n_overlap, 0);

    // Three 3-cycle digits with 5-cycle gaps
    clear();
    run(1'b1, 3); run(1'b0, 5);
    run(1'b1, 3); run(1'b0, 5);
    run(1'b1, 3); run(1'b0, 20);
    chk("s2_d_count", d_q.size(), 3);
    chk("s2_d0_cycle", at(d_q, 0) - s0, 6);
    chk("s2_d1_cycle", at(d_q, 1) - s0, 14);
    chk("s2_d2_cycle", at(d_q, 2) - s0, 22);
    chk("s2_c_count", c_q.size(), 1);
    chk("s2_c_after_d2", at(c_q, 0) - at(d_q, 2), 15);
    chk("s2_overlap", n_overlap, 0);
    chk("s2_err_count", e_q.size(), 0);

    // Too-short first mark
    clear();
    run(1'b1, 1);
    run(1'b0, 20);
    chk("s3_err_count", e_q.size(), 1);
    chk("s3_err_cycle", at(e_q, 0) - s0, 4);
    chk("s3_d_count", d_q.size(), 0);
    chk("s3_c_count", c_q.size(), 0);
    chk("s3_busy_after_err", busy_after_err, 0);
    chk("s3_busy_cycles", n_busy, 1);

    // Valid digit followed by an over-long mark
    clear();
    run(1'b1, 4);
    run(1'b0, 5);
    run(1'b1, 12);
    run(1'b0, 20);
    chk("s4_d_count", d_q.size(), 1);
    chk("s4_d_cycle", at(d_q, 0) - s0, 7);
    chk("s4_err_count", e_q.size(), 1);
    chk("s4_err_cycle", at(e_q, 0) - s0, 24);
    chk("s4_c_count", c_q.size(), 1);
    chk("s4_c_after_err", at(c_q, 0) - at(e_q, 0), 15);

    // Mark ignored while disabled
    clear();
    enable = 1'b0;
    run(1'b1, 4);
    run(1'b0, 20);
    chk("s5a_d_count", d_q.size(), 0);
    chk("s5a_c_count", c_q.size(), 0);
    chk("s5a_err_count", e_q.size(), 0);
    chk("s5a_busy_cycles", n_busy, 0);

    // Enable dropped inside GAP: read still completes
    clear();
    enable = 1'b1;
    run(1'b1, 4);
    run(1'b0, 5);
    enable = 1'b0;
    run(1'b0, 20);
    enable = 1'b1;
    chk("s5b_d_count", d_q.size(), 1);
    chk("s5b_d_cycle", at(d_q, 0) - s0, 7);
    chk("s5b_c_count", c_q.size(), 1);
    chk("s5b_c_cycle", at(c_q, 0) - s0, 22);

    // Reset during the third synchronized high cycle of a mark
    clear();
    run(1'b1, 4);
    chk("s6_busy_before_reset", n_busy, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("s6_in_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_outputs_zero("s6_after_release");
    clear();
    run(1'b1, 3);
    run(1'b0, 20);
    chk("s6_tail_d_count", d_q.size(), 0);
    chk("s6_tail_c_count", c_q.size(), 0);
    chk("s6_tail_err_count", e_q.size(), 0);
    chk("s6_tail_busy_cycles", n_busy, 0);

    clear();
    run(1'b1, 4);
    run(1'b0, 20);
    chk("s6_next_d_count", d_q.size(), 1);
    chk("s6_next_d_cycle", at(d_q, 0) - s0, 7);
    chk("s6_next_c_count", c_q.size(), 1);
    chk("s6_next_c_after_d", at(c_q, 0) - at(d_q, 0), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
